// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared types and constants for the register-bus transfer sequencer.
package bus_transfer_sequencer_pkg;

  localparam int unsigned XFER_CNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StLatch,
    StGap,
    StResp
  } state_e;

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_onehot_decoder.sv
// Index to one-hot enable decoder; all-zero when disabled or index out of range.
module bus_transfer_sequencer_onehot_decoder #(
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (32'(idx) == i);
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences tri-state out/in strobes on the shared register bus for src->dst moves.
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 4,
  parameter int unsigned IDX_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  register_clock,
  input  logic                  register_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [IDX_W-1:0]      cmd_src,
  input  logic [IDX_W-1:0]      cmd_dst,
  output logic [NUM_REGS-1:0]   reg_out_en,
  output logic [NUM_REGS-1:0]   reg_in_en,
  output logic                  xfer_done,
  output logic                  xfer_err,
  output logic                  bus_busy,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        src_q, src_d;
  logic [IDX_W-1:0]        dst_q, dst_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    resp_err_q, resp_err_d;
  logic [XFER_CNT_W-1:0]   xfer_count_q;
  logic                    drive_en, latch_en;
  logic                    done_d, err_d;
  logic [NUM_REGS-1:0]     out_en_d, in_en_d;

  assign cmd_ready  = (state_q == StIdle) && register_reset_n;
  assign xfer_count = xfer_count_q;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q;
    drive_en   = 1'b0;
    latch_en   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          if (!idx_in_range(32'(cmd_src), NUM_REGS) || !idx_in_range(32'(cmd_dst), NUM_REGS)) begin
            resp_err_d = 1'b1;
            state_d    = StResp;
          end else if (cmd_src == cmd_dst) begin
            resp_err_d = 1'b0;
            state_d    = StResp;
          end else begin
            cnt_d   = SettleLoad;
            state_d = StDrive;
          end
        end
      end
      StDrive: begin
        drive_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = StLatch;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLatch: begin
        // Source keeps driving while the destination captures on the closing edge.
        drive_en = 1'b1;
        latch_en = 1'b1;
        state_d  = StGap;
      end
      StGap: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StResp: begin
        done_d  = !resp_err_q;
        err_d   = resp_err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  bus_transfer_sequencer_onehot_decoder #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS)
  ) u_out_dec (
    .en     (drive_en),
    .idx    (src_q),
    .onehot (out_en_d)
  );

  bus_transfer_sequencer_onehot_decoder #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS)
  ) u_in_dec (
    .en     (latch_en),
    .idx    (dst_q),
    .onehot (in_en_d)
  );

  // Enables are flopped so the async reset drops them in the same instant it asserts.
  always_ff @(posedge register_clock or negedge register_reset_n) begin
    if (!register_reset_n) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
      reg_out_en   <= '0;
      reg_in_en    <= '0;
      xfer_done    <= 1'b0;
      xfer_err     <= 1'b0;
      bus_busy     <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
      reg_out_en <= out_en_d;
      reg_in_en  <= in_en_d;
      xfer_done  <= done_d;
      xfer_err   <= err_d;
      bus_busy   <= (state_d != StIdle);
      if (done_d) begin
        xfer_count_q <= xfer_count_q + XFER_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_bus_transfer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_src = '0;
  logic [2:0]  cmd_dst = '0;
  logic        cmd_ready;
  logic [3:0]  out_en, in_en;
  logic        done, err, busy;
  logic [15:0] count;

  logic        c3_valid = 1'b0;
  logic [1:0]  c3_src = '0;
  logic [1:0]  c3_dst = '0;
  logic        c3_ready;
  logic [3:0]  c3_out, c3_in;
  logic        c3_done, c3_err, c3_busy;
  logic [15:0] c3_count;

  always #5 clk = ~clk;

  bus_transfer_sequencer #(
    .NUM_REGS      (4),
    .IDX_W         (3),
    .SETTLE_CYCLES (1)
  ) dut (
    .register_clock   (clk),
    .register_reset_n (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_src          (cmd_src),
    .cmd_dst          (cmd_dst),
    .reg_out_en       (out_en),
    .reg_in_en        (in_en),
    .xfer_done        (done),
    .xfer_err         (err),
    .bus_busy         (busy),
    .xfer_count       (count)
  );

  bus_transfer_sequencer #(
    .NUM_REGS      (4),
    .IDX_W         (2),
    .SETTLE_CYCLES (3)
  ) dut3 (
    .register_clock   (clk),
    .register_reset_n (rst_n),
    .cmd_valid        (c3_valid),
    .cmd_ready        (c3_ready),
    .cmd_src          (c3_src),
    .cmd_dst          (c3_dst),
    .reg_out_en       (c3_out),
    .reg_in_en        (c3_in),
    .xfer_done        (c3_done),
    .xfer_err         (c3_err),
    .bus_busy         (c3_busy),
    .xfer_count       (c3_count)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register bank hanging off the bus.
  logic [15:0] bank [4];
  logic [15:0] bus;
  always_comb begin
    bus = '0;
    for (int i = 0; i < 4; i++) if (out_en[i]) bus = bank[i];
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      bank[0] <= 16'h1234;
      bank[1] <= 16'hBEEF;
      bank[2] <= 16'h0000;
      bank[3] <= 16'h5A5A;
    end else begin
      for (int i = 0; i < 4; i++) if (in_en[i]) bank[i] <= bus;
    end
  end

  typedef struct {
    logic        is_err;
    int unsigned accept;
    int unsigned lat;
    logic [3:0]  out_mask;
    int unsigned out_cycles;
    logic [3:0]  in_mask;
    int unsigned in_cycles;
    logic [15:0] cnt;
    int unsigned dst;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_bank [4];
  logic [15:0] model_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    model_bank[0] = 16'h1234;
    model_bank[1] = 16'hBEEF;
    model_bank[2] = 16'h0000;
    model_bank[3] = 16'h5A5A;
    model_count   = '0;
  endtask

  // Call at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [2:0] s, input logic [2:0] d, input logic hold);
    exp_t e;
    logic mv;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.is_err     = (s >= 3'd4) || (d >= 3'd4);
    mv           = !e.is_err && (s != d);
    e.accept     = cyc + 1;
    e.lat        = mv ? 3 : 1;
    e.out_mask   = mv ? (4'b0001 << s) : 4'b0000;
    e.out_cycles = mv ? 2 : 0;
    e.in_mask    = mv ? (4'b0001 << d) : 4'b0000;
    e.in_cycles  = mv ? 1 : 0;
    e.dst        = int'(d[1:0]);
    e.data       = model_bank[s[1:0]];
    if (mv) model_bank[d[1:0]] = model_bank[s[1:0]];
    if (!e.is_err) model_count = model_count + 16'd1;
    e.cnt = model_count;
    exp_q.push_back(e);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each done/err pulse.
  logic [3:0]  acc_out, acc_in, prev_out;
  int unsigned acc_out_cyc, acc_in_cyc;
  initial begin
    exp_t e;
    logic ok;
    acc_out = '0; acc_in = '0; prev_out = '0; acc_out_cyc = 0; acc_in_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_out = '0; acc_in = '0; prev_out = '0; acc_out_cyc = 0; acc_in_cyc = 0;
      end else begin
        ok = ($countones(out_en) <= 1) && ($countones(in_en) <= 1) &&
             !(in_en != 0 && out_en == 0) && ((in_en & out_en) == 0) &&
             !(prev_out != 0 && out_en != 0 && prev_out != out_en);
        chk("bus_invariant", 32'(ok), 32'd1);
        chk("done_err_exclusive", 32'(done && err), 32'd0);
        if (out_en != 0) acc_out_cyc++;
        if (in_en != 0) acc_in_cyc++;
        acc_out  = acc_out | out_en;
        acc_in   = acc_in | in_en;
        prev_out = out_en;
        if (done || err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_response", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_err", 32'(err), 32'(e.is_err));
            chk("resp_done", 32'(done), 32'(!e.is_err));
            chk("latency", cyc - e.accept, e.lat);
            chk("out_en_mask", 32'(acc_out), 32'(e.out_mask));
            chk("out_en_cycles", acc_out_cyc, e.out_cycles);
            chk("in_en_mask", 32'(acc_in), 32'(e.in_mask));
            chk("in_en_cycles", acc_in_cyc, e.in_cycles);
            chk("xfer_count", 32'(count), 32'(e.cnt));
            if (e.out_mask != 0) chk("dst_data", 32'(bank[e.dst]), 32'(e.data));
          end
          acc_out = '0; acc_in = '0; acc_out_cyc = 0; acc_in_cyc = 0;
        end
      end
    end
  end

  logic [3:0] exp3_out [7]  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
  logic [3:0] exp3_in [7]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
  logic       exp3_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       exp3_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_en", 32'(out_en), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready_held", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_done", 32'(done), 32'd0);
    @(negedge clk);

    // Single move 1->2 carrying 0xBEEF.
    send(3'd1, 3'd2, 1'b0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    drain();
    chk("move_count", 32'(count), 32'd1);
    chk("reg2_value", 32'(bank[2]), 32'hBEEF);

    // No-op and out-of-range commands.
    send(3'd2, 3'd2, 1'b0);
    send(3'd5, 3'd1, 1'b0);
    send(3'd0, 3'd4, 1'b0);
    drain();
    chk("noop_err_count", 32'(count), 32'd2);

    // Back-to-back moves with valid held; then a move whose inputs change mid-flight.
    send(3'd0, 3'd3, 1'b1);
    send(3'd3, 3'd0, 1'b1);
    send(3'd2, 3'd1, 1'b1);
    send(3'd3, 3'd3, 1'b0);
    drain();
    chk("b2b_reg3", 32'(bank[3]), 32'h1234);
    chk("b2b_reg1", 32'(bank[1]), 32'hBEEF);
    chk("b2b_count", 32'(count), 32'd6);

    // Reset while the source is driving.
    send(3'd0, 3'd1, 1'b0);
    @(negedge clk);
    chk("pre_reset_out_en", 32'(out_en), 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_out_en", 32'(out_en), 32'h0);
    chk("async_in_en", 32'(in_en), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Counter wrap from a preloaded value.
    force dut.xfer_count_q = 16'hFFFE;
    #1;
    release dut.xfer_count_q;
    model_count = 16'hFFFE;
    @(negedge clk);
    send(3'd1, 3'd1, 1'b0);
    send(3'd2, 3'd2, 1'b0);
    send(3'd5, 3'd5, 1'b0);
    drain();
    chk("wrap_count", 32'(count), 32'h0000);

    // SETTLE_CYCLES=3 instance: move 0->1 traced cycle by cycle.
    chk("s3_ready", 32'(c3_ready), 32'd1);
    c3_src   = 2'd0;
    c3_dst   = 2'd1;
    c3_valid = 1'b1;
    @(negedge clk);
    c3_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("s3_out_en_k%0d", k), 32'(c3_out), 32'(exp3_out[k]));
      chk($sformatf("s3_in_en_k%0d", k), 32'(c3_in), 32'(exp3_in[k]));
      chk($sformatf("s3_done_k%0d", k), 32'(c3_done), 32'(exp3_done[k]));
      chk($sformatf("s3_busy_k%0d", k), 32'(c3_busy), 32'(exp3_busy[k]));
      chk($sformatf("s3_err_k%0d", k), 32'(c3_err), 32'd0);
      @(negedge clk);
    end
    chk("s3_count", 32'(c3_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
